// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: write-data select encodings, default widths
// and the hazard-unit FSM state type.
package cpu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] WDSEL_ALU  = 2'b00;
  localparam logic [1:0] WDSEL_LOAD = 2'b01;
  localparam logic [1:0] WDSEL_PC4  = 2'b10;
  localparam logic [1:0] WDSEL_IMM  = 2'b11;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding selector. Priority: MEM, then WB, then the
// freeze hold register, then the register-file value. Index 0 never matches.
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] r,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_wR,
  input  logic              mem_is_ld,
  input  logic [XLEN-1:0]   mem_wd,
  input  logic [XLEN-1:0]   mem_rd,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wR,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              hold_valid,
  input  logic [REG_AW-1:0] hold_wR,
  input  logic [XLEN-1:0]   hold_wd,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   opnd
);

  logic r_nz;

  assign r_nz = (r != {REG_AW{1'b0}});

  // First matching producer wins; a MEM load supplies its load data.
  always_comb begin
    opnd = rdata;
    if (r_nz && mem_we && (mem_wR == r)) begin
      if (mem_is_ld) begin
        opnd = mem_rd;
      end else begin
        opnd = mem_wd;
      end
    end else if (r_nz && wb_we && (wb_wR == r)) begin
      opnd = wb_wd;
    end else if (r_nz && hold_valid && (hold_wR == r)) begin
      opnd = hold_wd;
    end else begin
      opnd = rdata;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding, load-use bubble generation and multi-cycle load
// freeze control with a hold register for the WB result retired at freeze
// entry, plus saturating stall counters and a sticky freeze timeout flag.
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NSRC     = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC*REG_AW-1:0] id_rR,
  input  logic [NSRC-1:0]        id_re,
  input  logic                   ex_we,
  input  logic [REG_AW-1:0]      ex_wR,
  input  logic [1:0]             ex_WDSel,
  input  logic [NSRC*REG_AW-1:0] ex_rR,
  input  logic [NSRC*XLEN-1:0]   ex_rdata,
  input  logic                   mem_we,
  input  logic [REG_AW-1:0]      mem_wR,
  input  logic [1:0]             mem_WDSel,
  input  logic [XLEN-1:0]        mem_wd,
  input  logic [XLEN-1:0]        mem_rd,
  input  logic                   mem_rd_valid,
  input  logic                   wb_we,
  input  logic [REG_AW-1:0]      wb_wR,
  input  logic [XLEN-1:0]        wb_wd,
  output logic [NSRC*XLEN-1:0]   ex_opnd,
  output logic                   stall_pc,
  output logic                   stall_ifid,
  output logic                   flush_idex,
  output logic                   freeze,
  output logic [CNT_W-1:0]       lu_cnt,
  output logic [CNT_W-1:0]       frz_cnt,
  output logic                   err_timeout
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0]  WAIT_LIM = WC_W'(WAIT_MAX);
  localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state, state_nxt;
  logic              hold_valid, hold_valid_nxt;
  logic [REG_AW-1:0] hold_wR, hold_wR_nxt;
  logic [XLEN-1:0]   hold_wd, hold_wd_nxt;
  logic [WC_W-1:0]   wait_cnt, wait_nxt;
  logic              err_nxt;
  logic              mem_is_ld;
  logic              ex_is_ld;
  logic              lu_hit;

  assign mem_is_ld  = mem_we && (mem_WDSel == WDSEL_LOAD);
  assign ex_is_ld   = ex_we && (ex_WDSel == WDSEL_LOAD) && (ex_wR != {REG_AW{1'b0}});
  assign freeze     = mem_is_ld && !mem_rd_valid;
  assign stall_pc   = freeze || lu_hit;
  assign stall_ifid = freeze || lu_hit;
  assign flush_idex = lu_hit && !freeze;

  // Load in EX whose destination is read by any enabled ID operand.
  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      lu_hit = lu_hit | (ex_is_ld && id_re[i] && (id_rR[i*REG_AW +: REG_AW] == ex_wR));
    end
  end

  // Per-operand forwarding selectors.
  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    fwd_mux #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
    ) u_fwd_mux (
      .r          (ex_rR[g*REG_AW +: REG_AW]),
      .mem_we     (mem_we),
      .mem_wR     (mem_wR),
      .mem_is_ld  (mem_is_ld),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd),
      .wb_we      (wb_we),
      .wb_wR      (wb_wR),
      .wb_wd      (wb_wd),
      .hold_valid (hold_valid),
      .hold_wR    (hold_wR),
      .hold_wd    (hold_wd),
      .rdata      (ex_rdata[g*XLEN +: XLEN]),
      .opnd       (ex_opnd[g*XLEN +: XLEN])
    );
  end

  // Freeze FSM next state, hold capture, wait counter and timeout flag.
  always_comb begin
    state_nxt      = state;
    hold_valid_nxt = hold_valid;
    hold_wR_nxt    = hold_wR;
    hold_wd_nxt    = hold_wd;
    wait_nxt       = wait_cnt;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt      = FREEZE;
          hold_valid_nxt = wb_we && (wb_wR != {REG_AW{1'b0}});
          hold_wR_nxt    = wb_wR;
          hold_wd_nxt    = wb_wd;
          wait_nxt       = WC_ONE;
        end else begin
          state_nxt = RUN;
        end
      end
      FREEZE: begin
        if (freeze) begin
          if (wait_cnt < WAIT_LIM) begin
            wait_nxt = wait_cnt + WC_ONE;
          end else begin
            wait_nxt = wait_cnt;
          end
        end else begin
          state_nxt      = RUN;
          hold_valid_nxt = 1'b0;
          wait_nxt       = {WC_W{1'b0}};
        end
      end
      default: begin
        state_nxt      = RUN;
        hold_valid_nxt = 1'b0;
        wait_nxt       = {WC_W{1'b0}};
      end
    endcase
    if (freeze && (wait_nxt >= WAIT_LIM)) begin
      err_nxt = 1'b1;
    end else begin
      err_nxt = err_timeout;
    end
  end

  // State, hold register, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      hold_valid  <= 1'b0;
      hold_wR     <= {REG_AW{1'b0}};
      hold_wd     <= {XLEN{1'b0}};
      wait_cnt    <= {WC_W{1'b0}};
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_valid  <= hold_valid_nxt;
      hold_wR     <= hold_wR_nxt;
      hold_wd     <= hold_wd_nxt;
      wait_cnt    <= wait_nxt;
      err_timeout <= err_nxt;
    end
  end

  // Saturating load-use bubble and freeze-cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt  <= {CNT_W{1'b0}};
      frz_cnt <= {CNT_W{1'b0}};
    end else begin
      if (flush_idex && (lu_cnt != CNT_MAX)) begin
        lu_cnt <= lu_cnt + CNT_ONE;
      end else begin
        lu_cnt <= lu_cnt;
      end
      if (freeze && (frz_cnt != CNT_MAX)) begin
        frz_cnt <= frz_cnt + CNT_ONE;
      end else begin
        frz_cnt <= frz_cnt;
      end
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the per-operand load-use forwarding mux in the EX stage.
- Forwards results for NSRC operands from MEM and WB to EX, detects ID/EX load-use hazards, and generates stall/bubble controls.
- Freezes the pipeline while a multi-cycle load is outstanding in MEM.
- Keeps a hold register for the WB result retired during a freeze, and counts stall cycles.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register-index width.
- NSRC, 2, source operands per instruction.
- WAIT_MAX, 15, freeze cycles before err_timeout sets.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- id_rR  in  NSRC*REG_AW  ID-stage source indices; operand i at [i*REG_AW +: REG_AW].
- id_re  in  NSRC  ID operand-read enables.
- ex_we  in  1  EX instruction writes a register.
- ex_wR  in  REG_AW  EX destination.
- ex_WDSel  in  2  EX write-data select; 2'b01 = load.
- ex_rR  in  NSRC*REG_AW  EX source indices.
- ex_rdata  in  NSRC*XLEN  register-file values latched into EX.
- mem_we  in  1  MEM writes a register.
- mem_wR  in  REG_AW  MEM destination.
- mem_WDSel  in  2  MEM write-data select.
- mem_wd  in  XLEN  MEM non-load result.
- mem_rd  in  XLEN  load data.
- mem_rd_valid  in  1  load data valid this cycle.
- wb_we  in  1  WB writes.
- wb_wR  in  REG_AW  WB destination.
- wb_wd  in  XLEN  WB data.
- ex_opnd  out  NSRC*XLEN  forwarded EX operands.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID.
- flush_idex  out  1  inject bubble into ID/EX.
- freeze  out  1  hold ID/EX and EX/MEM; WB gets a bubble.
- lu_cnt  out  CNT_W  load-use bubble count.
- frz_cnt  out  CNT_W  freeze-cycle count.
- err_timeout  out  1  sticky: freeze exceeded WAIT_MAX.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: state=RUN, hold_valid=0, hold_wR=0, hold_wd=0, wait_cnt=0, lu_cnt=0, frz_cnt=0, err_timeout=0.
- Combinational outputs during reset follow their equations.
- mem_is_ld = mem_we && mem_WDSel==2'b01.
- Register index 0 is never a forwarding or hazard match.
- Forwarding: combinational, zero latency. Per operand i, where r = ex_rR[i], first match wins:
  1. mem_we && mem_wR==r: select mem_rd if mem_is_ld, else mem_wd.
  2. wb_we && wb_wR==r: select wb_wd.
  3. hold_valid && hold_wR==r: select hold_wd.
  4. Otherwise: ex_rdata[i].
- Load-use detection: lu_hit = ex_we && ex_WDSel==2'b01 && ex_wR!=0 && some i with id_re[i] && id_rR[i]==ex_wR.
- When lu_hit && !freeze: stall_pc = stall_ifid = flush_idex = 1 for exactly one cycle. The next cycle the load sits in MEM, so the hazard self-resolves.
- Freeze: freeze = mem_is_ld && !mem_rd_valid, combinational.
  - While freeze=1: stall_pc=stall_ifid=1 and flush_idex=0, taking priority over lu_hit.
- FSM, two states:
  - RUN: if freeze, go to FREEZE. At that edge capture hold_wR/hold_wd from wb_*, and set hold_valid = wb_we && wb_wR!=0. Set wait_cnt=1.
  - FREEZE: while freeze=1, stay; wait_cnt increments, saturating.
  - FREEZE: if wait_cnt reaches WAIT_MAX while still frozen, set err_timeout (sticky until rst). The freeze itself continues.
  - FREEZE: on a cycle with mem_rd_valid=1 (release), freeze=0. The hold register remains usable this cycle. At the edge go to RUN, clear hold_valid and wait_cnt.
- The WB stage retires a bubble during a freeze, so the hold register covers the EX consumer of that WB result.
- Counters, saturating at all-ones:
  - lu_cnt increments on each cycle with lu_hit && !freeze.
  - frz_cnt increments on each cycle with freeze=1.
- Simultaneous events:
  - lu_hit during freeze is suppressed and re-evaluated after release.
  - mem_rd_valid in the first load cycle gives no freeze and no state change.
- Reset mid-freeze: immediate return to RUN, hold cleared, all outputs at reset values.

Decomposition:
- Shared package cpu_pkg holds:
  - WDSEL_ALU=2'b00, WDSEL_LOAD=2'b01, WDSEL_PC4=2'b10, WDSEL_IMM=2'b11;
  - XLEN and REG_AW defaults;
  - FSM state enum {RUN, FREEZE}.
- One natural sub-module: fwd_mux, a single-operand priority selector instantiated NSRC times via generate.

Test Plan:
- ex_rR[0]=5, mem_we=1, mem_wR=5, mem_WDSel=00, mem_wd=32'hAAAA0001, wb_wR=5, wb_wd=32'h1 -> ex_opnd[0]=32'hAAAA0001, because MEM beats WB.
- EX load: ex_we=1, ex_WDSel=01, ex_wR=7, id_rR[1]=7, id_re[1]=1 -> stall_pc=stall_ifid=flush_idex=1 for one cycle, lu_cnt=1. Same with ex_wR=0 -> no stall.
- mem_is_ld, mem_wR=3, mem_rd_valid=0 for 3 cycles while wb_we=1, wb_wR=9, wb_wd=32'h1234, then valid with mem_rd=32'hBEEF:
  - freeze=1 for 3 cycles, frz_cnt=3;
  - ex_rR[1]=9 yields 32'h1234 throughout, including the release cycle;
  - ex_rR[0]=3 yields 32'hBEEF on release;
  - hold_valid=0 after release.
- Freeze held for WAIT_MAX+2 cycles -> err_timeout=1 at cycle WAIT_MAX and stays 1 after release until rst.
- Assert rst asynchronously mid-freeze -> state RUN, counters 0, err_timeout 0, next cycle forwards from ex_rdata.
- lu_hit and freeze in the same cycle -> flush_idex=0, lu_cnt unchanged. After release the lu_hit condition re-fires and gives one bubble.
